axi4_burst_slave_mem: RTL and testbench
=======================================

AXI4_BURST_SLAVE_MEM -- requirements
Module: axi4_burst_slave_mem

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter DATA_W, default 32, SHALL set the data bus width in bits (32 or 64).
REQ-003 Parameter ADDR_W, default 32, SHALL set the byte-address width.
REQ-004 Parameter MEM_DEPTH, default 256, SHALL set the number of DATA_W-bit memory words.
REQ-005 Parameter ID_W, default 4, SHALL set the AXI ID width.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 AWID/AWADDR/AWLEN/AWSIZE/AWBURST  input  ID_W/ADDR_W/8/3/2  write address channel; AWVALID input 1, AWREADY output 1.
REQ-009 WDATA/WSTRB/WLAST  input  DATA_W/DATA_W/8/1  write data channel; WVALID input 1, WREADY output 1.
REQ-010 BID/BRESP  output  ID_W/2  write response; BVALID output 1, BREADY input 1.
REQ-011 ARID/ARADDR/ARLEN/ARSIZE/ARBURST  input  ID_W/ADDR_W/8/3/2  read address channel; ARVALID input 1, ARREADY output 1.
REQ-012 RID/RDATA/RRESP/RLAST  output  ID_W/DATA_W/2/1  read data channel; RVALID output 1, RREADY input 1.

Function
REQ-013 The write and read paths SHALL be independent FSMs and SHALL operate concurrently.
REQ-014 Write FSM SHALL have states W_IDLE, W_DATA and W_RESP: W_IDLE->W_DATA on the AW handshake; W_DATA->W_RESP on the W handshake with beat count == AWLEN; W_RESP->W_IDLE on the B handshake.
REQ-015 AWREADY SHALL be 1 only in W_IDLE, WREADY only in W_DATA, and BVALID only in W_RESP.
REQ-016 Read FSM SHALL have states R_IDLE and R_DATA: R_IDLE->R_DATA on the AR handshake; R_DATA->R_IDLE on the R handshake with RLAST=1.
REQ-017 ARREADY SHALL be 1 only in R_IDLE; the first RVALID SHALL assert exactly one cycle after the AR handshake.
REQ-018 AW/AR fields SHALL be latched on the handshake, and BID/RID SHALL return the latched ID.
REQ-019 Beat address SHALL follow burst type:
- FIXED (00): constant.
- INCR (01): +2^SIZE per beat.
- WRAP (10): wraps within an aligned block of (LEN+1)*2^SIZE bytes.
REQ-020 Address arithmetic SHALL be ADDR_W bits wide with modulo wrap-around; the word index SHALL be addr >> log2(DATA_W/8).
REQ-021 A burst SHALL be flagged as error if any of these holds:
- SIZE > log2(DATA_W/8).
- BURST == 11.
- WRAP with LEN not in {1,3,7,15}.
- Any beat word index >= MEM_DEPTH.
REQ-022 For an error write burst, the block SHALL accept all beats, SHALL suppress memory writes for the errored beats, and SHALL return BRESP=10 (SLVERR); otherwise it SHALL return BRESP=00.
REQ-023 Errored read beats SHALL return RDATA=0 and RRESP=10; good beats SHALL return RRESP=00.
REQ-024 Writes SHALL update only the byte lanes with WSTRB[i]=1, on the W handshake cycle.
REQ-025 RLAST SHALL be 1 exactly on beat ARLEN.
REQ-026 If WLAST mismatches the beat count, the write FSM SHALL still end at beat AWLEN and BRESP SHALL be 10.
REQ-027 While RVALID=1 and RREADY=0, RDATA, RRESP, RLAST and RID SHALL hold stable; the same holds for BVALID/BRESP/BID while BREADY=0.
REQ-028 A read of a word written in the same cycle SHALL return the pre-write value.

Reset
REQ-029 While rst=1, both FSMs SHALL enter IDLE and all outputs SHALL be 0 except AWREADY=1 and ARREADY=1 on the cycle after reset deasserts.
REQ-030 Reset mid-burst SHALL abandon the burst with no response issued; memory contents SHALL NOT be cleared.

Verification
REQ-031 INCR write at 0x20, LEN=3, SIZE=2, data A0000000..A0000003, then INCR read at 0x20 -> BRESP=00; RDATA A0000000..A0000003, RLAST on beat 3 only.
REQ-032 WRAP read at 0x38, LEN=3, SIZE=2 -> beat addresses 0x38, 0x3C, 0x30, 0x34.
REQ-033 Write at word MEM_DEPTH (0x400 for defaults) -> BRESP=10; readback of 0x3FC unchanged.
REQ-034 Word 0x40 = FFFFFFFF, then FIXED write 12345678 with WSTRB=0011 -> readback FFFF5678.
REQ-035 Read with RREADY held low 3 cycles per beat -> RDATA/RLAST stable; 4 beats delivered in order.
REQ-036 rst pulsed during beat 2 of a write -> no BVALID, AWREADY=1 next cycle, and a subsequent burst completes with BRESP=00.

Source files
------------

// File: rtl/axi4_burst_slave_mem_if.sv
// AXI4 bus bundle between a burst master and the memory slave.
// The slave modport is the memory's view; the master modport is the initiator's view.
interface axi4_burst_slave_mem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi4_burst_slave_mem.sv
// AXI4 burst slave backed by a DATA_W-wide word memory.
// Independent write (IDLE/DATA/RESP) and read (IDLE/DATA) FSMs; read beats are registered.
module axi4_burst_slave_mem #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_DEPTH = 256,
    parameter int ID_W      = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    axi4_burst_slave_mem_if.slave s_axi
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [1:0] RESP_OK     = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } burst_t;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    logic [DATA_W-1:0] r_mem [MEM_DEPTH];

    // Errors that apply to every beat of a burst regardless of address.
    function automatic logic f_bad_burst(input burst_t b);
        logic wrap_len_ok;
        wrap_len_ok = (b.len == 8'd1) || (b.len == 8'd3) || (b.len == 8'd7) || (b.len == 8'd15);
        f_bad_burst = (int'(b.size) > OFF_W) || (b.burst == 2'b11) ||
                      ((b.burst == 2'b10) && !wrap_len_ok);
    endfunction

    function automatic logic f_out_of_range(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] idx;
        idx = addr >> OFF_W;
        f_out_of_range = (idx >= ADDR_W'(MEM_DEPTH));
    endfunction

    // WRAP keeps the upper bits of the aligned (LEN+1)*2^SIZE block and wraps the low bits.
    function automatic logic [ADDR_W-1:0] f_next_addr(input burst_t b);
        logic [ADDR_W-1:0] stride, inc, mask;
        stride = ADDR_W'(1) << b.size;
        inc    = b.addr + stride;
        mask   = ((ADDR_W'(b.len) + ADDR_W'(1)) << b.size) - ADDR_W'(1);
        case (b.burst)
            2'b01:   f_next_addr = inc;
            2'b10:   f_next_addr = (b.addr & ~mask) | (inc & mask);
            default: f_next_addr = b.addr;
        endcase
    endfunction

    // ---------------- write path ----------------
    wstate_t          r_wstate, w_wnext;
    burst_t           r_aw, w_aw_req;
    logic [7:0]       r_wcnt;
    logic             r_wbad, r_werr;
    logic             w_awready, w_wready, w_bvalid;
    logic             w_aw_hs, w_w_hs, w_wbeat_err, w_wlast_exp;
    logic [IDX_W-1:0] w_widx;

    assign w_aw_req = '{id: s_axi.awid, addr: s_axi.awaddr, len: s_axi.awlen,
                        size: s_axi.awsize, burst: s_axi.awburst};
    assign w_aw_hs     = w_awready && s_axi.awvalid;
    assign w_w_hs      = w_wready && s_axi.wvalid;
    assign w_wlast_exp = (r_wcnt == r_aw.len);
    assign w_widx      = r_aw.addr[OFF_W +: IDX_W];
    assign w_wbeat_err = r_wbad || f_out_of_range(r_aw.addr);

    always_ff @(posedge i_clk) begin
        if (i_rst) r_wstate <= W_IDLE;
        else       r_wstate <= w_wnext;
    end

    always_comb begin
        w_wnext   = r_wstate;
        w_awready = 1'b0;
        w_wready  = 1'b0;
        w_bvalid  = 1'b0;
        if (!i_rst) begin
            case (r_wstate)
                W_IDLE: begin
                    w_awready = 1'b1;
                    if (s_axi.awvalid) w_wnext = W_DATA;
                end
                W_DATA: begin
                    w_wready = 1'b1;
                    if (s_axi.wvalid && w_wlast_exp) w_wnext = W_RESP;
                end
                W_RESP: begin
                    w_bvalid = 1'b1;
                    if (s_axi.bready) w_wnext = W_IDLE;
                end
                default: w_wnext = W_IDLE;
            endcase
        end
    end

    // A WLAST mismatch poisons the response but does not block the beat's write.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_aw   <= '0;
            r_wcnt <= '0;
            r_wbad <= 1'b0;
            r_werr <= 1'b0;
        end else if (w_aw_hs) begin
            r_aw   <= w_aw_req;
            r_wcnt <= '0;
            r_wbad <= f_bad_burst(w_aw_req);
            r_werr <= f_bad_burst(w_aw_req);
        end else if (w_w_hs) begin
            r_aw.addr <= f_next_addr(r_aw);
            r_wcnt    <= r_wcnt + 8'd1;
            r_werr    <= r_werr || w_wbeat_err || (s_axi.wlast != w_wlast_exp);
        end
    end

    // Memory is deliberately outside reset so a reset mid-burst keeps its contents.
    always_ff @(posedge i_clk) begin
        if (w_w_hs && !w_wbeat_err) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (s_axi.wstrb[i]) r_mem[w_widx][8*i +: 8] <= s_axi.wdata[8*i +: 8];
            end
        end
    end

    assign s_axi.awready = w_awready;
    assign s_axi.wready  = w_wready;
    assign s_axi.bvalid  = w_bvalid;
    assign s_axi.bid     = w_bvalid ? r_aw.id : '0;
    assign s_axi.bresp   = (w_bvalid && r_werr) ? RESP_SLVERR : RESP_OK;

    // ---------------- read path ----------------
    rstate_t           r_rstate, w_rnext;
    burst_t            r_ar, w_ar_req;
    logic [7:0]        r_rcnt;
    logic              r_rbad;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rresp;
    logic              w_arready, w_rvalid, w_ar_hs, w_r_hs, w_rlast;
    logic              w_ld, w_ld_bad, w_ld_err;
    logic [ADDR_W-1:0] w_rnext_addr, w_ld_addr;

    assign w_ar_req = '{id: s_axi.arid, addr: s_axi.araddr, len: s_axi.arlen,
                        size: s_axi.arsize, burst: s_axi.arburst};
    assign w_ar_hs      = w_arready && s_axi.arvalid;
    assign w_r_hs       = w_rvalid && s_axi.rready;
    assign w_rlast      = (r_rcnt == r_ar.len);
    assign w_rnext_addr = f_next_addr(r_ar);

    // The beat register loads on AR accept and on every non-final R accept, so
    // the memory is sampled at the edge and same-cycle writes are not visible.
    assign w_ld      = w_ar_hs || (w_r_hs && !w_rlast);
    assign w_ld_addr = w_ar_hs ? w_ar_req.addr : w_rnext_addr;
    assign w_ld_bad  = w_ar_hs ? f_bad_burst(w_ar_req) : r_rbad;
    assign w_ld_err  = w_ld_bad || f_out_of_range(w_ld_addr);

    always_ff @(posedge i_clk) begin
        if (i_rst) r_rstate <= R_IDLE;
        else       r_rstate <= w_rnext;
    end

    always_comb begin
        w_rnext   = r_rstate;
        w_arready = 1'b0;
        w_rvalid  = 1'b0;
        if (!i_rst) begin
            case (r_rstate)
                R_IDLE: begin
                    w_arready = 1'b1;
                    if (s_axi.arvalid) w_rnext = R_DATA;
                end
                R_DATA: begin
                    w_rvalid = 1'b1;
                    if (s_axi.rready && w_rlast) w_rnext = R_IDLE;
                end
                default: w_rnext = R_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ar    <= '0;
            r_rcnt  <= '0;
            r_rbad  <= 1'b0;
            r_rdata <= '0;
            r_rresp <= RESP_OK;
        end else begin
            if (w_ar_hs) begin
                r_ar   <= w_ar_req;
                r_rcnt <= '0;
                r_rbad <= w_ld_bad;
            end else if (w_r_hs && !w_rlast) begin
                r_ar.addr <= w_rnext_addr;
                r_rcnt    <= r_rcnt + 8'd1;
            end
            if (w_ld) begin
                r_rdata <= w_ld_err ? '0 : r_mem[w_ld_addr[OFF_W +: IDX_W]];
                r_rresp <= w_ld_err ? RESP_SLVERR : RESP_OK;
            end
        end
    end

    assign s_axi.arready = w_arready;
    assign s_axi.rvalid  = w_rvalid;
    assign s_axi.rid     = w_rvalid ? r_ar.id : '0;
    assign s_axi.rdata   = w_rvalid ? r_rdata : '0;
    assign s_axi.rresp   = w_rvalid ? r_rresp : RESP_OK;
    assign s_axi.rlast   = w_rvalid && w_rlast;
endmodule

// File: tb/tb_axi4_burst_slave_mem.sv
// Directed bench for axi4_burst_slave_mem: bursts, wrap, errors, strobes, backpressure, reset.
module tb_axi4_burst_slave_mem;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int MEM_DEPTH = 256;
    localparam int ID_W      = 4;
    localparam int LIMIT     = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi4_burst_slave_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) bus ();

    axi4_burst_slave_mem #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH), .ID_W(ID_W)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .s_axi(bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [3:0]  rd_id   [16];
    logic [1:0]  b_resp;
    logic [3:0]  b_id;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wait(input string tag, input int n);
        checks++;
        assert (n < LIMIT) else begin
            errors++;
            $error("FAIL %s: observed %0d cycles expected < %0d", tag, n, LIMIT);
        end
    endtask

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input logic [31:0] dbase, input logic [3:0] strb, input int last_at);
        int n;
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
        bus.awvalid = 1'b1;
        n = 0;
        while (bus.awready !== 1'b1 && n < LIMIT) begin step(); n++; end
        chk_wait("aw_wait", n);
        step();
        bus.awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            bus.wdata = dbase + 32'(i); bus.wstrb = strb; bus.wlast = (i == last_at);
            bus.wvalid = 1'b1;
            n = 0;
            while (bus.wready !== 1'b1 && n < LIMIT) begin step(); n++; end
            chk_wait("w_wait", n);
            step();
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.bready = 1'b1;
        n = 0;
        while (bus.bvalid !== 1'b1 && n < LIMIT) begin step(); n++; end
        chk_wait("b_wait", n);
        b_resp = bus.bresp; b_id = bus.bid;
        step();
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int stall);
        int n;
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
        bus.arvalid = 1'b1; bus.rready = 1'b0;
        n = 0;
        while (bus.arready !== 1'b1 && n < LIMIT) begin step(); n++; end
        chk_wait("ar_wait", n);
        step();
        bus.arvalid = 1'b0;
        chk("rvalid_first_cycle", 64'(bus.rvalid), 64'd1);
        for (int b = 0; b <= int'(len); b++) begin
            n = 0;
            while (bus.rvalid !== 1'b1 && n < LIMIT) begin step(); n++; end
            chk_wait("r_wait", n);
            rd_data[b] = bus.rdata; rd_resp[b] = bus.rresp; rd_last[b] = bus.rlast; rd_id[b] = bus.rid;
            for (int s = 0; s < stall; s++) begin
                step();
                chk("rvalid_hold", 64'(bus.rvalid), 64'd1);
                chk("rdata_hold", 64'(bus.rdata), 64'(rd_data[b]));
                chk("rlast_hold", 64'(bus.rlast), 64'(rd_last[b]));
            end
            bus.rready = 1'b1;
            step();
            bus.rready = 1'b0;
        end
        chk("rvalid_drop", 64'(bus.rvalid), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
        bus.arburst = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

        // Reset: everything low while asserted, readies high right after release.
        #1;
        chk("rst_awready", 64'(bus.awready), 64'd0);
        chk("rst_arready", 64'(bus.arready), 64'd0);
        step(); step();
        chk("rst_awready2", 64'(bus.awready), 64'd0);
        chk("rst_bvalid", 64'(bus.bvalid), 64'd0);
        chk("rst_rvalid", 64'(bus.rvalid), 64'd0);
        rst = 1'b0;
        step();
        chk("post_rst_awready", 64'(bus.awready), 64'd1);
        chk("post_rst_arready", 64'(bus.arready), 64'd1);
        chk("post_rst_wready", 64'(bus.wready), 64'd0);

        // INCR write then INCR readback.
        axi_write(4'd5, 32'h20, 8'd3, 3'd2, 2'b01, 32'hA000_0000, 4'hF, 3);
        chk("incr_bresp", 64'(b_resp), 64'd0);
        chk("incr_bid", 64'(b_id), 64'd5);
        axi_read(4'd6, 32'h20, 8'd3, 3'd2, 2'b01, 0);
        for (int b = 0; b < 4; b++) begin
            chk("incr_rdata", 64'(rd_data[b]), 64'(32'hA000_0000 + 32'(b)));
            chk("incr_rresp", 64'(rd_resp[b]), 64'd0);
            chk("incr_rlast", 64'(rd_last[b]), 64'(b == 3));
            chk("incr_rid", 64'(rd_id[b]), 64'd6);
        end

        // WRAP read from 0x38 within the 16-byte block at 0x30.
        axi_write(4'd1, 32'h30, 8'd3, 3'd2, 2'b01, 32'hB000_0000, 4'hF, 3);
        chk("wrap_prep_bresp", 64'(b_resp), 64'd0);
        axi_read(4'd7, 32'h38, 8'd3, 3'd2, 2'b10, 0);
        for (int b = 0; b < 4; b++) begin
            chk("wrap_rdata", 64'(rd_data[b]), 64'(32'hB000_0000 + 32'(((8 + 4*b) % 16) / 4)));
            chk("wrap_rresp", 64'(rd_resp[b]), 64'd0);
        end

        // Out-of-range word: write rejected, neighbour untouched, read returns zero + SLVERR.
        axi_write(4'd2, 32'h3FC, 8'd0, 3'd2, 2'b01, 32'hC0FF_EE00, 4'hF, 0);
        chk("edge_bresp", 64'(b_resp), 64'd0);
        axi_write(4'd3, 32'h400, 8'd0, 3'd2, 2'b01, 32'hDEAD_BEEF, 4'hF, 0);
        chk("oor_bresp", 64'(b_resp), 64'd2);
        chk("oor_bid", 64'(b_id), 64'd3);
        axi_read(4'd4, 32'h3FC, 8'd0, 3'd2, 2'b01, 0);
        chk("edge_rdata", 64'(rd_data[0]), 64'(32'hC0FF_EE00));
        chk("edge_rlast", 64'(rd_last[0]), 64'd1);
        axi_read(4'd4, 32'h400, 8'd0, 3'd2, 2'b01, 0);
        chk("oor_rdata", 64'(rd_data[0]), 64'd0);
        chk("oor_rresp", 64'(rd_resp[0]), 64'd2);

        // Byte strobes and FIXED bursts.
        axi_write(4'd0, 32'h40, 8'd0, 3'd2, 2'b01, 32'hFFFF_FFFF, 4'hF, 0);
        axi_write(4'd0, 32'h40, 8'd0, 3'd2, 2'b00, 32'h1234_5678, 4'b0011, 0);
        chk("strb_bresp", 64'(b_resp), 64'd0);
        axi_read(4'd0, 32'h40, 8'd0, 3'd2, 2'b01, 0);
        chk("strb_rdata", 64'(rd_data[0]), 64'(32'hFFFF_5678));
        axi_write(4'd0, 32'h44, 8'd1, 3'd2, 2'b00, 32'h1111_0000, 4'hF, 1);
        axi_read(4'd0, 32'h44, 8'd0, 3'd2, 2'b01, 0);
        chk("fixed_rdata", 64'(rd_data[0]), 64'(32'h1111_0001));

        // Malformed bursts answer SLVERR and leave memory alone.
        axi_write(4'd9, 32'h50, 8'd0, 3'd2, 2'b01, 32'h5555_5555, 4'hF, 0);
        axi_write(4'd9, 32'h50, 8'd0, 3'd3, 2'b01, 32'h0BAD_0001, 4'hF, 0);
        chk("size_bresp", 64'(b_resp), 64'd2);
        axi_write(4'd9, 32'h50, 8'd0, 3'd2, 2'b11, 32'h0BAD_0002, 4'hF, 0);
        chk("burst11_bresp", 64'(b_resp), 64'd2);
        axi_write(4'd9, 32'h50, 8'd2, 3'd2, 2'b10, 32'h0BAD_0003, 4'hF, 2);
        chk("wraplen_bresp", 64'(b_resp), 64'd2);
        axi_read(4'd9, 32'h50, 8'd0, 3'd2, 2'b01, 0);
        chk("err_nowrite", 64'(rd_data[0]), 64'(32'h5555_5555));
        axi_write(4'd9, 32'h60, 8'd3, 3'd2, 2'b01, 32'hE000_0000, 4'hF, 1);
        chk("early_wlast_bresp", 64'(b_resp), 64'd2);
        axi_write(4'd9, 32'h60, 8'd1, 3'd2, 2'b01, 32'hE000_0000, 4'hF, 99);
        chk("missing_wlast_bresp", 64'(b_resp), 64'd2);
        axi_read(4'd8, 32'h20, 8'd1, 3'd3, 2'b01, 0);
        for (int b = 0; b < 2; b++) begin
            chk("rd_err_rdata", 64'(rd_data[b]), 64'd0);
            chk("rd_err_rresp", 64'(rd_resp[b]), 64'd2);
            chk("rd_err_rlast", 64'(rd_last[b]), 64'(b == 1));
        end

        // Read backpressure: 3 stall cycles per beat.
        axi_read(4'hA, 32'h20, 8'd3, 3'd2, 2'b01, 3);
        for (int b = 0; b < 4; b++) begin
            chk("stall_rdata", 64'(rd_data[b]), 64'(32'hA000_0000 + 32'(b)));
            chk("stall_rlast", 64'(rd_last[b]), 64'(b == 3));
        end

        // Reset during beat 2 of a write burst.
        bus.awid = 4'd2; bus.awaddr = 32'h80; bus.awlen = 8'd3; bus.awsize = 3'd2; bus.awburst = 2'b01;
        bus.awvalid = 1'b1;
        step();
        bus.awvalid = 1'b0;
        bus.wstrb = 4'hF; bus.wlast = 1'b0; bus.wvalid = 1'b1;
        bus.wdata = 32'h7700_0000;
        step();
        bus.wdata = 32'h7700_0001;
        step();
        bus.wdata = 32'h7700_0002;
        rst = 1'b1;
        step();
        chk("midrst_bvalid", 64'(bus.bvalid), 64'd0);
        chk("midrst_wready", 64'(bus.wready), 64'd0);
        rst = 1'b0;
        bus.wvalid = 1'b0;
        step();
        chk("midrst_awready", 64'(bus.awready), 64'd1);
        chk("midrst_bvalid2", 64'(bus.bvalid), 64'd0);
        axi_write(4'd2, 32'h80, 8'd1, 3'd2, 2'b01, 32'hD000_0000, 4'hF, 1);
        chk("midrst_bresp", 64'(b_resp), 64'd0);
        axi_read(4'd2, 32'h80, 8'd1, 3'd2, 2'b01, 0);
        chk("midrst_rdata0", 64'(rd_data[0]), 64'(32'hD000_0000));
        chk("midrst_rdata1", 64'(rd_data[1]), 64'(32'hD000_0001));
        axi_read(4'd2, 32'h20, 8'd0, 3'd2, 2'b01, 0);
        chk("midrst_mem_kept", 64'(rd_data[0]), 64'(32'hA000_0000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
